commit_trace_buffer: RTL

- Consumer end of the CPU commit/debug interface. Captures each retired instruction's commit record into an in-order FIFO.
- Exposes captured records to the host or bench through a valid/ready stream.
- Requests CPU stalls (back-pressure on global_en) before the FIFO overflows.
- Tracks halt status, a retired-instruction count and an enabled-cycle count. Sits between the CPU core and the host/difftest side.

---
 rtl/commit_trace_buffer_pkg.sv | 23 ++
 rtl/commit_trace_buffer_if.sv | 32 +++
 rtl/commit_trace_buffer_trace_fifo.sv | 56 +++++
 rtl/commit_trace_buffer.sv | 111 +++++++++++
 4 files changed

// File: rtl/commit_trace_buffer_pkg.sv
// Shared types and constants for the commit trace buffer: the trace entry
// layout, the HALT instruction encoding and the default FIFO depth.
package commit_trace_buffer_pkg;

  localparam int unsigned DEPTH_DEFAULT = 16;
  localparam logic [31:0] HALT_INST     = 32'h8000_0000;

  // Field order is fixed; the FIFO stores the packed struct as one word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        dmem_we;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
  } trace_entry_t;

  localparam int unsigned TRACE_W = $bits(trace_entry_t);

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Trace output stream of the commit trace buffer: head-entry fields plus
// the valid/ready pair; master is the buffer, slave is the host/difftest.
interface commit_trace_buffer_if;

  // Handshake: an entry moves on every cycle where trace_valid and
  // trace_ready are both high; trace_valid never depends on trace_ready,
  // and the head fields stay stable while trace_valid is high and unaccepted.
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
  logic        trace_halt;
  logic        trace_reg_we;
  logic [4:0]  trace_reg_wa;
  logic [31:0] trace_reg_wd;
  logic        trace_dmem_we;
  logic [31:0] trace_dmem_wa;
  logic [31:0] trace_dmem_wd;

  modport master (
    output trace_valid, trace_pc, trace_inst, trace_halt, trace_reg_we,
           trace_reg_wa, trace_reg_wd, trace_dmem_we, trace_dmem_wa, trace_dmem_wd,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_pc, trace_inst, trace_halt, trace_reg_we,
           trace_reg_wa, trace_reg_wd, trace_dmem_we, trace_dmem_wa, trace_dmem_wd,
    output trace_ready
  );

endinterface

// File: rtl/commit_trace_buffer_trace_fifo.sv
// Synchronous show-ahead FIFO: head is read combinationally from storage,
// push and pop may coincide at any occupancy including full.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == COUNT_FULL);
    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the head slot that wr_ptr points at.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Consumer end of the CPU commit interface: captures retired-instruction
// records into an in-order FIFO, requests stalls, tracks halt and counters.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              global_en,
    input  logic              commit,
    input  logic [31:0]       commit_pc,
    input  logic [31:0]       commit_inst,
    input  logic              commit_halt,
    input  logic              commit_reg_we,
    input  logic [4:0]        commit_reg_wa,
    input  logic [31:0]       commit_reg_wd,
    input  logic              commit_dmem_we,
    input  logic [31:0]       commit_dmem_wa,
    input  logic [31:0]       commit_dmem_wd,
    input  logic              clr,
    commit_trace_buffer_if.master trace,
    output logic              stall_req,
    output logic              halted,
    output logic              overflow,
    output logic [CNT_W-1:0]  inst_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic         fifo_rst;
    logic         en_q;
    logic         capture;
    logic         pop;
    logic         store;
    logic         fifo_full;
    logic         fifo_empty;
    logic [AW:0]  fifo_count;
    trace_entry_t in_entry;
    trace_entry_t head_entry;

    assign fifo_rst = rst | clr;
    // The commit register holds while global_en is low, so only the first
    // cycle after an enabled cycle carries a fresh record.
    assign capture  = commit & en_q & ~halted;
    assign pop      = trace.trace_valid & trace.trace_ready;
    assign store    = capture & (~fifo_full | pop);

    always_comb begin
        in_entry         = '0;
        in_entry.pc      = commit_pc;
        in_entry.inst    = commit_inst;
        in_entry.halt    = commit_halt;
        in_entry.reg_we  = commit_reg_we;
        in_entry.reg_wa  = commit_reg_wa;
        in_entry.reg_wd  = commit_reg_wd;
        in_entry.dmem_we = commit_dmem_we;
        in_entry.dmem_wa = commit_dmem_wa;
        in_entry.dmem_wd = commit_dmem_wd;
    end

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .rst       (fifo_rst),
        .push      (store),
        .push_data (in_entry),
        .pop       (pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign trace.trace_valid   = ~fifo_empty;
    assign trace.trace_pc      = head_entry.pc;
    assign trace.trace_inst    = head_entry.inst;
    assign trace.trace_halt    = head_entry.halt;
    assign trace.trace_reg_we  = head_entry.reg_we;
    assign trace.trace_reg_wa  = head_entry.reg_wa;
    assign trace.trace_reg_wd  = head_entry.reg_wd;
    assign trace.trace_dmem_we = head_entry.dmem_we;
    assign trace.trace_dmem_wa = head_entry.dmem_wa;
    assign trace.trace_dmem_wd = head_entry.dmem_wd;

    // One slot of headroom absorbs the record already in flight when the
    // host drops global_en.
    assign stall_req = (32'(fifo_count) >= DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            en_q      <= 1'b0;
            halted    <= 1'b0;
            overflow  <= 1'b0;
            inst_cnt  <= '0;
            cycle_cnt <= '0;
        end else begin
            en_q <= global_en;
            if (capture && commit_halt)         halted   <= 1'b1;
            if (capture && fifo_full && !pop)   overflow <= 1'b1;
            if (store && inst_cnt != '1)        inst_cnt <= inst_cnt + CNT_W'(1);
            if (global_en && !halted && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

endmodule
